// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Pulls bytes from the TX FIFO over a valid/ready handshake and shifts them
// onto the UART line as: start bit, DATA_BITS data bits (LSB first), an
// optional parity bit, then STOP_BITS stop bits. Bit timing is counted in
// pulses of the shared baud-tick strobe enable_clk.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset; abandons any frame in flight
//   enable_clk  baud tick strobe, one clk wide
//   data_in     byte from the FIFO; bits above DATA_BITS-1 are ignored
//   data_valid  data_in holds a byte
//   data_ready  serializer can take a byte this cycle (IDLE only)
//   tx          serial line, idles high
//   busy        a frame is in progress
//   tx_done     one-clk pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_clk,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Wide enough to count a two-stop-bit STOP period without wrapping.
    localparam int TW = $clog2(TICKS_PER_BIT * 2);

    localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * TICKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          bitEnd;
    logic          stopEnd;

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            tick_q   <= '0;
            bitCnt_q <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            tick_q   <= tick_d;
            bitCnt_q <= bitCnt_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. The tx value for the coming bit is computed here so
    // the line changes on the very edge that starts that bit.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        tick_d   = tick_q;
        bitCnt_d = bitCnt_q;
        par_d    = par_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        bitEnd  = enable_clk && (tick_q == BIT_LAST);
        stopEnd = enable_clk && (tick_q == STOP_LAST);

        // Ticks only count inside a frame; a bit-ending edge overrides this.
        if (state_q != IDLE && enable_clk) begin
            tick_d = tick_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (data_valid && ready_q) begin
                    shreg_d = data_in & DATA_MASK;
                    par_d   = (^(data_in & DATA_MASK)) ^ 1'(PARITY_ODD);
                    tick_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    tick_d   = '0;
                    bitCnt_d = '0;
                    state_d  = DATA;
                    tx_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    // The counter is held on the last bit so it cannot wrap
                    // when DATA_BITS is 8.
                    if (bitCnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        tx_d     = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    tick_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // All stop bits are one long period, so its own terminal count.
                if (stopEnd) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign data_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Five serializer instances with different parameter sets share clk and rst:
//   0: defaults (8N1, 16 ticks/bit), enable_clk every 4th clk, gateable
//   1: 8 data, even parity, 2 ticks/bit, enable_clk constant
//   2: 8 data, odd parity,  2 ticks/bit, enable_clk constant
//   3: 5 data, 2 stop bits, 2 ticks/bit, enable_clk constant
//   4: 8N1, 1 tick/bit, enable_clk constant (back-to-back frames)
// Expected frames are written by hand as {stop bits, parity, data, start}.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int NDUT = 5;

    localparam bit [NDUT-1:0][3:0] DB_CFG  = {4'd8, 4'd5, 4'd8, 4'd8, 4'd8};
    localparam bit [NDUT-1:0]      PEN_CFG = 5'b00110;
    localparam bit [NDUT-1:0]      ODD_CFG = 5'b00100;
    localparam bit [NDUT-1:0]      SB2_CFG = 5'b01000;
    localparam bit [NDUT-1:0][4:0] TPB_CFG = {5'd1, 5'd2, 5'd2, 5'd2, 5'd16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enDiv = 1'b0;
    logic enGate = 1'b1;
    logic enFast = 1'b1;
    int   divCnt = 0;

    logic [7:0]      dataIn [NDUT];
    logic [NDUT-1:0] validVec = '0;
    wire  [NDUT-1:0] enVec = {{(NDUT-1){enFast}}, enDiv & enGate};
    wire  [NDUT-1:0] readyVec, txVec, busyVec, doneVec;

    int hs [NDUT] = '{default: 0};
    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        uart_tx_serializer #(
            .DATA_BITS    (int'(DB_CFG[g])),
            .PARITY_EN    (int'(PEN_CFG[g])),
            .PARITY_ODD   (int'(ODD_CFG[g])),
            .STOP_BITS    (SB2_CFG[g] ? 2 : 1),
            .TICKS_PER_BIT(int'(TPB_CFG[g]))
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .enable_clk(enVec[g]),
            .data_in   (dataIn[g]),
            .data_valid(validVec[g]),
            .data_ready(readyVec[g]),
            .tx        (txVec[g]),
            .busy      (busyVec[g]),
            .tx_done   (doneVec[g])
        );
    end

    // Baud divider for instance 0: one enable per 4 clks, changed on negedge.
    initial begin
        forever begin
            @(negedge clk);
            divCnt = (divCnt + 1) % 4;
            enDiv  = (divCnt == 0);
        end
    end

    // Handshake counter: inputs only change just after posedge, so the
    // negedge sees exactly what the next edge will see.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (validVec[i] && readyVec[i] && !rst) hs[i]++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] value, input logic valid);
        dataIn[idx]   = value;
        validVec[idx] = valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one byte and samples tx mid-bit. stallAt/stallLen gate instance
    // 0's enable off for stallLen clks; pulseAt raises data_valid mid-frame.
    task automatic runFrame(input int idx, input logic [7:0] value, input int nBits,
                            input int cpb, input logic [11:0] expFrame, input string tag,
                            input int pulseAt, input int stallAt, input int stallLen);
        int doneC;
        int doneCnt;
        int busyDrop;
        int nextBit;
        int frameLen;
        int guard;
        logic [11:0] got;
        doneC    = -1;
        doneCnt  = 0;
        busyDrop = 0;
        nextBit  = 0;
        got      = '0;
        frameLen = nBits * cpb + stallLen;
        if (idx == 0) begin
            // Make the accept edge coincide with an enable edge.
            guard = 0;
            while (!enDiv && guard < 8) begin
                step();
                guard++;
            end
            repeat (3) step();
        end
        applyStimulus(idx, value, 1'b1);
        step();
        applyStimulus(idx, ~value, 1'b0);
        checkOutput({tag, "_accept"}, 32'({txVec[idx], busyVec[idx], readyVec[idx]}), 32'b010);
        for (int c = 0; c <= frameLen + 3; c++) begin
            int mid;
            mid = nextBit * cpb + cpb / 2;
            if (stallLen > 0 && mid >= stallAt) mid += stallLen;
            if (nextBit < nBits && c == mid) begin
                got[nextBit] = txVec[idx];
                nextBit++;
            end
            if (doneVec[idx]) begin
                doneCnt++;
                if (doneC < 0) doneC = c;
            end
            if (c < frameLen && !busyVec[idx]) busyDrop++;
            if (c == pulseAt) applyStimulus(idx, 8'hFF, 1'b1);
            if (c == pulseAt + 1) applyStimulus(idx, 8'h00, 1'b0);
            if (c == stallAt) enGate = 1'b0;
            if (c == stallAt + stallLen) enGate = 1'b1;
            step();
        end
        checkOutput({tag, "_bits"}, 32'(got), 32'(expFrame));
        checkOutput({tag, "_done_at"}, 32'(doneC), 32'(frameLen));
        checkOutput({tag, "_done_pulses"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, "_busy_gaps"}, 32'(busyDrop), 32'd0);
        checkOutput({tag, "_idle_line"}, 32'({txVec[idx], busyVec[idx], readyVec[idx]}), 32'b101);
    endtask

    initial begin
        logic [20:0] line;
        int          doneC;
        int          acc2C;
        logic        prevBusy;
        int          extraDone;

        for (int i = 0; i < NDUT; i++) dataIn[i] = 8'h00;

        // Reset with the clock running, then idle with enables active.
        repeat (3) step();
        checkOutput("rst_ready", 32'(readyVec), 32'h1F);
        checkOutput("rst_tx", 32'(txVec), 32'h1F);
        checkOutput("rst_busy", 32'(busyVec), 32'h00);
        checkOutput("rst_done", 32'(doneVec), 32'h00);
        rst = 1'b0;
        repeat (20) step();
        checkOutput("idle_tx", 32'(txVec), 32'h1F);
        checkOutput("idle_busy", 32'(busyVec), 32'h00);

        // Default parameters, 0xA5: 10 bits x 64 clk.
        runFrame(0, 8'hA5, 10, 64, {2'b00, 1'b1, 8'hA5, 1'b0}, "a5_8n1", -1, -1, 0);

        // Mid-frame valid pulse and a 100-clk enable stall inside data bit 2.
        runFrame(0, 8'h3C, 10, 64, {2'b00, 1'b1, 8'h3C, 1'b0}, "stall_3c", 100, 202, 100);

        // Parity: A5 has four ones, 07 has three.
        runFrame(1, 8'hA5, 11, 2, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, "par_even_a5", -1, -1, 0);
        runFrame(2, 8'hA5, 11, 2, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, "par_odd_a5", -1, -1, 0);
        runFrame(1, 8'h07, 11, 2, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, "par_even_07", -1, -1, 0);

        // Five data bits, two stop bits: 8 bit periods.
        runFrame(3, 8'hFF, 8, 2, {4'b0000, 2'b11, 5'b11111, 1'b0}, "w5s2_ff", -1, -1, 0);

        // Back-to-back on instance 4 with data_valid held high.
        applyStimulus(4, 8'h55, 1'b1);
        step();
        applyStimulus(4, 8'h0F, 1'b1);
        line     = '0;
        doneC    = -1;
        acc2C    = -1;
        prevBusy = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c <= 20) line[c] = txVec[4];
            if (doneVec[4] && doneC < 0) doneC = c;
            if (c > 0 && busyVec[4] && !prevBusy && acc2C < 0) begin
                acc2C = c;
                applyStimulus(4, 8'h00, 1'b0);
            end
            prevBusy = busyVec[4];
            step();
        end
        checkOutput("b2b_done_at", 32'(doneC), 32'd10);
        checkOutput("b2b_second_accept", 32'(acc2C), 32'd11);
        checkOutput("b2b_frame0", 32'(line[9:0]), 32'({1'b1, 8'h55, 1'b0}));
        checkOutput("b2b_gap_high", 32'(line[10]), 32'd1);
        checkOutput("b2b_frame1", 32'(line[20:11]), 32'({1'b1, 8'h0F, 1'b0}));
        checkOutput("b2b_handshakes", 32'(hs[4]), 32'd2);

        // Reset in the middle of DATA: line must rise before the next edge.
        applyStimulus(0, 8'h00, 1'b1);
        step();
        applyStimulus(0, 8'h00, 1'b0);
        repeat (100) step();
        checkOutput("mid_rst_pre_tx", 32'(txVec[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_async", 32'({txVec[0], busyVec[0], readyVec[0], doneVec[0]}),
                    32'b1010);
        step();
        rst = 1'b0;
        extraDone = 0;
        for (int c = 0; c < 700; c++) begin
            if (doneVec[0] || !txVec[0] || busyVec[0]) extraDone++;
            step();
        end
        checkOutput("mid_rst_frame_lost", 32'(extraDone), 32'd0);
        checkOutput("hs_dut0", 32'(hs[0]), 32'd3);
        checkOutput("hs_dut1", 32'(hs[1]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
